panda_lsu_ctrl: RTL and testbench
=================================

// Module: panda_lsu_ctrl
// PURPOSE
//  Load/store sequencer between the execute stage and the data memory port.
//  Takes one load/store command (width LSU_WIDTH_BYTE/HALF/WORD, signed/unsigned).
//  Drives a req/gnt/rvalid data bus with byte enables.
//  Splits misaligned accesses into two aligned word transactions, then merges and extends load data.
// PARAMETERS
//  ALLOW_MISALIGNED  1  1: split accesses that cross a word boundary; 0: return err_o without bus access
// PORTS
//  clk_i          in   1   clock, all state on rising edge
//  rst_i          in   1   asynchronous, active-high reset
//  req_i          in   1   command valid; accepted only when busy_o=0
//  we_i           in   1   1=store, 0=load
//  width_i        in   2   lsu_width_e
//  sign_ext_i     in   1   load sign-extend (LB/LH=1, LBU/LHU=0); ignored for word/store
//  addr_i         in   32  byte address
//  wdata_i        in   32  store data, right-aligned
//  busy_o         out  1   command in flight
//  done_o         out  1   one-cycle completion pulse
//  err_o          out  1   valid with done_o: bus error, misaligned (ALLOW_MISALIGNED=0) or width_i=2'b11
//  rdata_o        out  32  extended load data, valid with done_o (0 for stores/errors)
//  data_req_o     out  1   bus request
//  data_gnt_i     in   1   bus grant
//  data_rvalid_i  in   1   response valid
//  data_err_i     in   1   response error, qualified by data_rvalid_i
//  data_addr_o    out  32  word-aligned bus address
//  data_we_o      out  1   bus write enable
//  data_be_o      out  4   byte enables
//  data_wdata_o   out  32  byte-lane-aligned write data
//  data_rdata_i   in   32  read data
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0 (busy, done, err, rdata, data_req, addr, we, be, wdata).
//  FSM: IDLE -> GNT0 -> RVALID0 -> [GNT1 -> RVALID1] -> DONE -> IDLE.
//   IDLE: req_i latches command; next state GNT0 (or DONE+err for illegal width/disallowed misaligned).
//   GNTx: data_req_o=1, addr/we/be/wdata held stable until data_gnt_i=1.
//   RVALIDx: data_req_o=0; wait for data_rvalid_i.
//   RVALID0 -> GNT1 if split and no error, else DONE.
//   DONE: done_o=1 for exactly one cycle; then IDLE.
//  busy_o=1 in every state except IDLE. req_i while busy_o=1 is ignored (not queued).
//  Outputs are registered: aligned access with immediate gnt and rvalid one cycle later:
//   req_i sampled edge N; data_req_o high cycle N+1; rvalid N+2; done_o N+3.
//  Lane math: off=addr[1:0]; mask = 1/3/F for byte/half/word; be_full[7:0] = mask << off.
//   be0 = be_full[3:0] at {addr[31:2],2'b00}.
//   split iff be_full[7:4]!=0; be1 = be_full[7:4] at base+4 (wraps mod 2^32).
//   data_wdata_o = wdata_i rotated left by 8*off, same value for both halves.
//   Load: merged = {rdata1, rdata0} >> 8*off (rdata1=0 if not split); low 8/16/32 bits extended per sign_ext_i.
//  Errors: data_err_i on first half -> no second transaction, err_o=1; on second half -> err_o=1.
//  Stray data_rvalid_i in IDLE/GNTx is ignored. One outstanding transaction max.
//  Reset mid-operation: immediate return to IDLE, data_req_o drops asynchronously, no done_o;
//   a late rvalid after reset is ignored.
// TESTING
//  1 LW addr=0x100, gnt immediate, rdata=0xDEADBEEF -> be=F, addr=0x100, done_o N+3, rdata_o=0xDEADBEEF.
//  2 LB addr=0x103 signed, rdata=0x80xxxxxx -> be=8, rdata_o=0xFFFFFF80; LBU -> 0x00000080.
//  3 SW addr=0x202 wdata=0x11223344 -> txn0 addr=0x200 be=C wdata=0x33441122;
//    txn1 addr=0x204 be=3; single done_o, err_o=0.
//  4 LH addr=0x0FF gnt stalled 3 cycles each, rdata0=0xAAxxxxxx, rdata1=0xxxxxxxBB -> rdata_o=0xFFFFBBAA; req stable while stalled.
//  5 misaligned LW addr=0x301, data_err_i on first rvalid -> no second req, done_o with err_o=1;
//    ALLOW_MISALIGNED=0 -> err_o, zero bus requests.
//  6 rst_i pulsed during GNT1 -> data_req_o=0 same cycle, busy_o=0, no done_o; next LW completes normally.

Source files
------------

// File: rtl/panda_lsu_ctrl.sv
// Load/store sequencer: turns one execute-stage command into one or two aligned
// req/gnt/rvalid bus transactions, then merges and extends the returned load data.
module panda_lsu_ctrl #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  width_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [1:0] {
    LSU_WIDTH_BYTE = 2'b00,
    LSU_WIDTH_HALF = 2'b01,
    LSU_WIDTH_WORD = 2'b10
  } lsu_width_e;

  typedef enum logic [2:0] {
    IDLE, GNT0, RVALID0, GNT1, RVALID1, DONE
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, sign_q, split_q, err_q;
  logic [1:0]  width_q, off_q;
  logic [3:0]  be1_q;
  logic [31:0] rdata0_q, rdata_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  // Lane math on the incoming command
  logic [3:0]  mask_in;
  logic [7:0]  be_full;
  logic        split_in, illegal_in;
  logic [63:0] wdata_rot64;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mask_in = 4'h0;
    case (width_i)
      LSU_WIDTH_BYTE: mask_in = 4'h1;
      LSU_WIDTH_HALF: mask_in = 4'h3;
      LSU_WIDTH_WORD: mask_in = 4'hF;
      default:        mask_in = 4'h0;
    endcase
  end

  assign be_full     = {4'h0, mask_in} << addr_i[1:0];
  assign split_in    = |be_full[7:4];
  assign illegal_in  = (width_i == 2'b11) || (split_in && !ALLOW_MISALIGNED);
  assign wdata_rot64 = {wdata_i, wdata_i} << {addr_i[1:0], 3'b000};

  // Load merge: second word (if any) sits above the first before shifting down
  logic [31:0] merge_hi, merge_lo, load_ext;
  logic [63:0] merged;

  assign merge_hi = (state_q == RVALID1) ? data_rdata_i : 32'h0;
  assign merge_lo = (state_q == RVALID1) ? rdata0_q : data_rdata_i;
  assign merged   = {merge_hi, merge_lo} >> {off_q, 3'b000};

  always_comb begin
    load_ext = merged[31:0];
    case (width_q)
      LSU_WIDTH_BYTE: load_ext = {{24{sign_q & merged[7]}}, merged[7:0]};
      LSU_WIDTH_HALF: load_ext = {{16{sign_q & merged[15]}}, merged[15:0]};
      default:        load_ext = merged[31:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i) state_d = illegal_in ? DONE : GNT0;
      GNT0:    if (data_gnt_i) state_d = RVALID0;
      RVALID0: if (data_rvalid_i) state_d = (data_err_i || !split_q) ? DONE : GNT1;
      GNT1:    if (data_gnt_i) state_d = RVALID1;
      RVALID1: if (data_rvalid_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q     <= 1'b0;
      sign_q   <= 1'b0;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      width_q  <= 2'b00;
      off_q    <= 2'b00;
      be1_q    <= 4'h0;
      rdata0_q <= 32'h0;
      rdata_q  <= 32'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      be_q     <= 4'h0;
    end else begin
      case (state_q)
        IDLE: if (req_i) begin
          we_q    <= we_i;
          sign_q  <= sign_ext_i;
          split_q <= split_in;
          err_q   <= illegal_in;
          width_q <= width_i;
          off_q   <= addr_i[1:0];
          be1_q   <= be_full[7:4];
          rdata_q <= 32'h0;
          addr_q  <= {addr_i[31:2], 2'b00};
          be_q    <= be_full[3:0];
          wdata_q <= wdata_rot64[63:32];
        end
        RVALID0: if (data_rvalid_i) begin
          if (data_err_i) begin
            err_q <= 1'b1;
          end else if (split_q) begin
            rdata0_q <= data_rdata_i;
            addr_q   <= addr_q + 32'd4;
            be_q     <= be1_q;
          end else if (!we_q) begin
            rdata_q <= load_ext;
          end
        end
        RVALID1: if (data_rvalid_i) begin
          if (data_err_i) err_q <= 1'b1;
          else if (!we_q) rdata_q <= load_ext;
        end
        DONE: begin
          err_q   <= 1'b0;
          rdata_q <= 32'h0;
        end
        default: ;
      endcase
    end
  end

  // All outputs decode directly from registers, so reset clears them asynchronously
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign err_o        = done_o & err_q;
  assign rdata_o      = rdata_q;
  assign data_req_o   = (state_q == GNT0) || (state_q == GNT1);
  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_panda_lsu_ctrl.sv
// Directed bench for panda_lsu_ctrl: a vector table with a small bus responder,
// plus hand sequences for reset mid-operation and the no-misaligned variant.
module tb_panda_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i, we_i, sign_ext_i;
  logic [1:0]  width_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        data_req_o, data_gnt_i, data_rvalid_i, data_err_i, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;

  // Second instance with misaligned accesses disallowed; its bus never responds
  logic        na_req_i;
  logic        na_busy_o, na_done_o, na_err_o, na_data_req_o, na_data_we_o;
  logic [31:0] na_rdata_o, na_data_addr_o, na_data_wdata_o;
  logic [3:0]  na_data_be_o;
  int          na_req_count = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  panda_lsu_ctrl #(.ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .width_i(width_i),
    .sign_ext_i(sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_err_i(data_err_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
  );

  panda_lsu_ctrl #(.ALLOW_MISALIGNED(1'b0)) u_dut_na (
    .clk_i(clk), .rst_i(rst_i), .req_i(na_req_i), .we_i(1'b0), .width_i(2'b10),
    .sign_ext_i(1'b0), .addr_i(32'h0000_0301), .wdata_i(32'h0),
    .busy_o(na_busy_o), .done_o(na_done_o), .err_o(na_err_o), .rdata_o(na_rdata_o),
    .data_req_o(na_data_req_o), .data_gnt_i(1'b1), .data_rvalid_i(1'b0),
    .data_err_i(1'b0), .data_addr_o(na_data_addr_o), .data_we_o(na_data_we_o),
    .data_be_o(na_data_be_o), .data_wdata_o(na_data_wdata_o), .data_rdata_i(32'h0)
  );

  always @(posedge clk) if (na_data_req_o) na_req_count++;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  width;
    logic        sgn;
    logic [31:0] addr, wdata, rd0, rd1;
    int          err_at;   // 0 none, 1 first response, 2 second response
    int          stall;    // cycles of withheld grant per transaction
    int          exp_ntxn;
    logic [31:0] exp_a0;
    logic [3:0]  exp_be0;
    logic [31:0] exp_a1;
    logic [3:0]  exp_be1;
    logic [31:0] exp_wd;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] a[2], wd[2], hold_a;
    logic [3:0]  be[2], hold_be;
    logic        we_s[2];
    logic        err_s, stable;
    logic [31:0] rd_s;
    int          ntxn, lat, stall_cnt;
    bit          rv_pend, done_seen;
    ntxn = 0; lat = 0; stall_cnt = 0; rv_pend = 0; done_seen = 0;
    stable = 1'b1; err_s = 1'b0; rd_s = 32'h0; hold_a = 32'h0; hold_be = 4'h0;
    for (int i = 0; i < 2; i++) begin a[i] = 32'h0; wd[i] = 32'h0; be[i] = 4'h0; we_s[i] = 1'b0; end
    @(negedge clk);
    req_i = 1'b1; we_i = v.we; width_i = v.width; sign_ext_i = v.sgn;
    addr_i = v.addr; wdata_i = v.wdata;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      @(negedge clk);
      lat++;
      req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
      data_rdata_i = 32'h0;
      if (done_o) begin
        done_seen = 1'b1; err_s = err_o; rd_s = rdata_o;
      end else if (rv_pend) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = (ntxn == 1) ? v.rd0 : v.rd1;
        data_err_i    = (v.err_at == ntxn);
        rv_pend = 1'b0;
      end else if (data_req_o) begin
        if (stall_cnt == 0) begin
          hold_a = data_addr_o; hold_be = data_be_o;
        end else if (data_addr_o !== hold_a || data_be_o !== hold_be) begin
          stable = 1'b0;
        end
        if (stall_cnt == v.stall) begin
          data_gnt_i = 1'b1;
          if (ntxn < 2) begin
            a[ntxn] = data_addr_o; be[ntxn] = data_be_o;
            wd[ntxn] = data_wdata_o; we_s[ntxn] = data_we_o;
          end
          ntxn++; stall_cnt = 0; rv_pend = 1'b1;
        end else begin
          stall_cnt++;
        end
      end
    end
    check({v.name, ".done_seen"}, 32'(done_seen), 32'd1);
    check({v.name, ".latency"}, lat, v.exp_ntxn * (2 + v.stall) + 1);
    check({v.name, ".ntxn"}, ntxn, v.exp_ntxn);
    check({v.name, ".err"}, 32'(err_s), 32'(v.exp_err));
    check({v.name, ".rdata"}, rd_s, v.exp_rd);
    check({v.name, ".req_stable"}, 32'(stable), 32'd1);
    if (v.exp_ntxn >= 1) begin
      check({v.name, ".addr0"}, a[0], v.exp_a0);
      check({v.name, ".be0"}, 32'(be[0]), 32'(v.exp_be0));
      check({v.name, ".wdata0"}, wd[0], v.exp_wd);
      check({v.name, ".we0"}, 32'(we_s[0]), 32'(v.we));
    end
    if (v.exp_ntxn == 2) begin
      check({v.name, ".addr1"}, a[1], v.exp_a1);
      check({v.name, ".be1"}, 32'(be[1]), 32'(v.exp_be1));
      check({v.name, ".wdata1"}, wd[1], v.exp_wd);
    end
    @(negedge clk);
    check({v.name, ".done_one_cycle"}, {30'h0, done_o, busy_o}, 32'h0);
  endtask

  initial begin
    bit found;
    int done_cnt;
    //           name        we    wid    sgn   addr          wdata         rd0           rd1           ea st n  a0            be0    a1            be1    wd            err   rd
    vecs[0]  = '{"lw_al",    1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'h0,       0, 0, 1, 32'h0000_0100, 4'hF, 32'h0,        4'h0, 32'h0,        1'b0, 32'hDEAD_BEEF};
    vecs[1]  = '{"lb_s",     1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h8012_3456, 32'h0,       0, 0, 1, 32'h0000_0100, 4'h8, 32'h0,        4'h0, 32'h0,        1'b0, 32'hFFFF_FF80};
    vecs[2]  = '{"lbu",      1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h8012_3456, 32'h0,       0, 0, 1, 32'h0000_0100, 4'h8, 32'h0,        4'h0, 32'h0,        1'b0, 32'h0000_0080};
    vecs[3]  = '{"sw_split", 1'b1, 2'b10, 1'b0, 32'h0000_0202, 32'h1122_3344, 32'h0,        32'h0,       0, 0, 2, 32'h0000_0200, 4'hC, 32'h0000_0204, 4'h3, 32'h3344_1122, 1'b0, 32'h0};
    vecs[4]  = '{"lh_stall", 1'b0, 2'b01, 1'b1, 32'h0000_00FF, 32'h0,        32'hAA00_0000, 32'h0000_00BB, 0, 3, 2, 32'h0000_00FC, 4'h8, 32'h0000_0100, 4'h1, 32'h0,        1'b0, 32'hFFFF_BBAA};
    vecs[5]  = '{"lw_err0",  1'b0, 2'b10, 1'b0, 32'h0000_0301, 32'h0,        32'h1234_5678, 32'h0,       1, 0, 1, 32'h0000_0300, 4'hE, 32'h0,        4'h0, 32'h0,        1'b1, 32'h0};
    vecs[6]  = '{"bad_wid",  1'b0, 2'b11, 1'b0, 32'h0000_0400, 32'h0,        32'h0,        32'h0,       0, 0, 0, 32'h0,        4'h0, 32'h0,        4'h0, 32'h0,        1'b1, 32'h0};
    vecs[7]  = '{"lhu",      1'b0, 2'b01, 1'b0, 32'h0000_0402, 32'h0,        32'h9ABC_1234, 32'h0,       0, 0, 1, 32'h0000_0400, 4'hC, 32'h0,        4'h0, 32'h0,        1'b0, 32'h0000_9ABC};
    vecs[8]  = '{"sb",       1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h0000_00A5, 32'h0,        32'h0,       0, 0, 1, 32'h0000_0004, 4'h2, 32'h0,        4'h0, 32'h0000_A500, 1'b0, 32'h0};
    vecs[9]  = '{"lw_wrap_e1", 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0,      32'h1111_2222, 32'h3333_4444, 2, 0, 2, 32'hFFFF_FFFC, 4'hC, 32'h0000_0000, 4'h3, 32'h0,      1'b1, 32'h0};
    vecs[10] = '{"lw_split", 1'b0, 2'b10, 1'b0, 32'h0000_1001, 32'h0,        32'h4433_2211, 32'h8877_6655, 0, 1, 2, 32'h0000_1000, 4'hE, 32'h0000_1004, 4'h1, 32'h0,        1'b0, 32'h5544_3322};

    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; width_i = 2'b00; sign_ext_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    data_err_i = 1'b0; data_rdata_i = 32'h0; na_req_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.ctrl", {28'h0, busy_o, done_o, err_o, data_req_o}, 32'h0);
    check("reset.rdata", rdata_o, 32'h0);
    check("reset.addr", data_addr_o, 32'h0);
    check("reset.be_we", {27'h0, data_be_o, data_we_o}, 32'h0);
    check("reset.wdata", data_wdata_o, 32'h0);
    rst_i = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Reset while the second half of a split store is waiting for its grant
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; width_i = 2'b10; addr_i = 32'h0000_0202; wdata_i = 32'h1122_3344;
    found = 1'b0;
    begin
      bit rv_pend = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk);
        req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        if (data_req_o && data_addr_o == 32'h0000_0204) found = 1'b1;
        else if (rv_pend) begin data_rvalid_i = 1'b1; rv_pend = 1'b0; end
        else if (data_req_o) begin data_gnt_i = 1'b1; rv_pend = 1'b1; end
      end
    end
    check("rst_mid.reached_gnt1", 32'(found), 32'd1);
    rst_i = 1'b1;
    #1;
    check("rst_mid.req_busy_done", {29'h0, data_req_o, busy_o, done_o}, 32'h0);
    @(negedge clk);
    rst_i = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE_F00D;
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      data_rvalid_i = 1'b0;
      if (done_o || busy_o || data_req_o) done_cnt++;
    end
    check("rst_mid.late_rvalid_ignored", done_cnt, 0);
    run_vec(vecs[0]);

    // Disallowed misaligned access: immediate error, never touches the bus
    @(negedge clk);
    na_req_i = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      na_req_i = 1'b0;
      if (na_done_o) begin
        found = 1'b1;
        check("no_mis.err", 32'(na_err_o), 32'd1);
        check("no_mis.rdata", na_rdata_o, 32'h0);
      end
    end
    check("no_mis.done_seen", 32'(found), 32'd1);
    check("no_mis.bus_reqs", na_req_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
